// File: rtl/decim_mac_scheduler.sv
// Shared-MAC scheduler for the FIR and two halfband decimation stages: fixed-priority
// arbitration, tap sequencing with clear/last strobes, completion pulses and overrun flags.
module decim_mac_scheduler #(
    parameter int FIR_NUM_TAPS = 26,
    parameter int HB_NUM_TAPS  = 7,
    parameter int TAP_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       req,
    output logic [2:0]       gnt,
    output logic [TAP_W-1:0] tap_idx,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             mac_last,
    output logic [2:0]       done,
    output logic             busy,
    output logic [2:0]       overrun
);

    localparam logic [TAP_W-1:0] FIR_LAST = TAP_W'(FIR_NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] HB_LAST  = TAP_W'(HB_NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] HB_CTR   = TAP_W'((HB_NUM_TAPS - 1) / 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [2:0]       pending, pending_n;
    logic [2:0]       gnt_n, done_n, overrun_n, winner, grant_now, active;
    logic [TAP_W-1:0] tap_n;
    logic             mac_en_n, mac_clr_n, mac_last_n, busy_n, start;

    // Halfband walks the even taps and detours through the odd centre tap.
    function automatic logic [TAP_W-1:0] next_tap(input logic [TAP_W-1:0] t, input logic is_fir);
        if (is_fir || t == HB_CTR || t + 1'b1 == HB_CTR)
            return t + 1'b1;
        return t + TAP_W'(2);
    endfunction

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        tap_n      = '0;
        mac_en_n   = 1'b0;
        mac_clr_n  = 1'b0;
        mac_last_n = 1'b0;
        done_n     = '0;
        grant_now  = '0;
        start      = 1'b0;

        winner = '0;
        if (pending[0])      winner = 3'b001;
        else if (pending[1]) winner = 3'b010;
        else if (pending[2]) winner = 3'b100;

        active = pending | ((state == RUN) ? gnt : 3'b000);

        case (state)
            IDLE: start = en && (|pending);
            RUN: begin
                if (mac_last) begin
                    state_n = DONE;
                    done_n  = gnt;
                    gnt_n   = '0;
                end else begin
                    tap_n      = next_tap(tap_idx, gnt[0]);
                    mac_en_n   = 1'b1;
                    mac_last_n = (tap_n == (gnt[0] ? FIR_LAST : HB_LAST));
                end
            end
            DONE: begin
                start   = en && (|pending);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n   = RUN;
            gnt_n     = winner;
            grant_now = winner;
            tap_n     = '0;
            mac_en_n  = 1'b1;
            mac_clr_n = 1'b1;
        end

        // A request for a stage already queued or running is flagged, not re-queued.
        pending_n = (pending & ~grant_now) | (req & ~active);
        overrun_n = overrun | (req & active);
        busy_n    = (state_n != IDLE) || (|pending_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            gnt      <= '0;
            tap_idx  <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
            done     <= '0;
            busy     <= 1'b0;
            overrun  <= '0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            gnt      <= gnt_n;
            tap_idx  <= tap_n;
            mac_en   <= mac_en_n;
            mac_clr  <= mac_clr_n;
            mac_last <= mac_last_n;
            done     <= done_n;
            busy     <= busy_n;
            overrun  <= overrun_n;
        end
    end

endmodule

// File: tb/tb_decim_mac_scheduler.sv
// Scoreboard bench for decim_mac_scheduler: expected MAC beats and done pulses are queued
// when requests are driven and compared by a monitor; scenario tasks check timing inline.
module tb_decim_mac_scheduler;

    localparam int FIR_N = 26;
    localparam int HB_N  = 7;
    localparam int TW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [2:0]    req = '0;
    logic [2:0]    gnt, done, overrun;
    logic [TW-1:0] tap_idx;
    logic          mac_en, mac_clr, mac_last, busy;

    decim_mac_scheduler #(.FIR_NUM_TAPS(FIR_N), .HB_NUM_TAPS(HB_N), .TAP_W(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt), .tap_idx(tap_idx),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .done(done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    g;
        logic [TW-1:0] t;
        logic          c;
        logic          l;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] done_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_done_cyc[3];
    int         done_cnt[3];
    logic       mon_on   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (mac_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat cyc=%0d got gnt=%b tap=%0d required no MAC cycle", cyc, gnt, tap_idx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({gnt, tap_idx, mac_clr, mac_last} !== {e.g, e.t, e.c, e.l}) begin
                        n_fail++;
                        $display("FAIL beat cyc=%0d got gnt=%b tap=%0d clr=%b last=%b required gnt=%b tap=%0d clr=%b last=%b",
                                 cyc, gnt, tap_idx, mac_clr, mac_last, e.g, e.t, e.c, e.l);
                    end
                end
            end else begin
                n_checks++;
                if ({tap_idx, mac_clr, mac_last} !== '0 || gnt === 3'bxxx) begin
                    n_fail++;
                    $display("FAIL idle_outputs cyc=%0d got tap=%0d clr=%b last=%b required 0 0 0", cyc, tap_idx, mac_clr, mac_last);
                end
            end
            if (done !== 3'b000) begin
                n_checks++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done cyc=%0d got %b required 000", cyc, done);
                end else begin
                    logic [2:0] d;
                    d = done_q.pop_front();
                    if (done !== d) begin
                        n_fail++;
                        $display("FAIL done_order cyc=%0d got %b required %b", cyc, done, d);
                    end
                end
                for (int i = 0; i < 3; i++)
                    if (done[i] === 1'b1) begin
                        last_done_cyc[i] = cyc;
                        done_cnt[i]++;
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < k) tick();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [2:0] bits);
        req = bits;
        tick();
        req = '0;
    endtask

    task automatic push_job(input int s);
        int taps[$];
        if (s == 0) begin
            for (int i = 0; i < FIR_N; i++) taps.push_back(i);
        end else begin
            for (int i = 0; i < HB_N; i++)
                if (i % 2 == 0 || i == (HB_N - 1) / 2) taps.push_back(i);
        end
        for (int j = 0; j < taps.size(); j++) begin
            beat_t b;
            b.g = 3'(1 << s);
            b.t = TW'(taps[j]);
            b.c = (j == 0);
            b.l = (j == taps.size() - 1);
            exp_q.push_back(b);
        end
        done_q.push_back(3'(1 << s));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        n_checks++;
        if (n >= 300 || exp_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got beats_left=%0d dones_left=%0d required 0 0", name, exp_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({gnt, tap_idx, mac_en, mac_clr, mac_last, done, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got gnt=%b tap=%0d en=%b clr=%b last=%b done=%b busy=%b ovr=%b required all 0",
                     gnt, tap_idx, mac_en, mac_clr, mac_last, done, busy, overrun);
        end
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_fir();
        int c;
        logic [2:0] eg, ed;
        logic ec, el, eb;
        c = cyc;
        push_job(0);
        pulse_req(3'b001);
        for (int k = 1; k <= 30; k++) begin
            goto_cyc(c + k);
            eg = (k >= 2 && k <= 27) ? 3'b001 : 3'b000;
            ec = (k == 2);
            el = (k == 27);
            ed = (k == 28) ? 3'b001 : 3'b000;
            eb = (k <= 28);
            n_checks++;
            if ({gnt, mac_en, mac_clr, mac_last, done, busy} !== {eg, eg[0], ec, el, ed, eb}) begin
                n_fail++;
                $display("FAIL fir_timing k=%0d got gnt=%b en=%b clr=%b last=%b done=%b busy=%b required gnt=%b en=%b clr=%b last=%b done=%b busy=%b",
                         k, gnt, mac_en, mac_clr, mac_last, done, busy, eg, eg[0], ec, el, ed, eb);
            end
        end
        wait_idle("fir");
    endtask

    task automatic test_single_hb1();
        int c;
        c = cyc;
        push_job(1);
        pulse_req(3'b010);
        wait_idle("hb1");
        n_checks++;
        if (last_done_cyc[1] != c + 7) begin
            n_fail++;
            $display("FAIL hb1_done_cycle got %0d required %0d", last_done_cyc[1], c + 7);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int exp_cyc[3];
        c = cyc;
        exp_cyc = '{c + 28, c + 34, c + 40};
        push_job(0);
        push_job(1);
        push_job(2);
        pulse_req(3'b111);
        wait_idle("b2b");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (last_done_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL b2b_done%0d_cycle got %0d required %0d", i, last_done_cyc[i], exp_cyc[i]);
            end
        end
        n_checks++;
        if (overrun !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_overrun got %b required 000", overrun);
        end
    endtask

    task automatic test_overrun();
        int c, d0;
        c = cyc;
        d0 = done_cnt[0];
        push_job(0);
        pulse_req(3'b001);
        goto_cyc(c + 10);
        tick();
        pulse_req(3'b001);
        goto_cyc(c + 11);
        n_checks++;
        if (overrun !== 3'b001) begin
            n_fail++;
            $display("FAIL overrun_mid got %b required 001", overrun);
        end
        while (cyc < c + 27) tick();
        pulse_req(3'b001);
        wait_idle("overrun");
        n_checks++;
        if (overrun !== 3'b001) begin
            n_fail++;
            $display("FAIL overrun_sticky got %b required 001", overrun);
        end
        n_checks++;
        if (done_cnt[0] - d0 != 1) begin
            n_fail++;
            $display("FAIL overrun_done_count got %0d required 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_en_low();
        int c;
        c = cyc;
        push_job(2);
        push_job(0);
        pulse_req(3'b100);
        while (cyc < c + 3) tick();
        en = 1'b0;
        pulse_req(3'b001);
        for (int k = 8; k <= 12; k++) begin
            goto_cyc(c + k);
            n_checks++;
            if ({gnt, mac_en, busy} !== {3'b000, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL en_low_hold k=%0d got gnt=%b en=%b busy=%b required 000 0 1", k, gnt, mac_en, busy);
            end
        end
        n_checks++;
        if (last_done_cyc[2] != c + 7) begin
            n_fail++;
            $display("FAIL en_low_hb2_done got %0d required %0d", last_done_cyc[2], c + 7);
        end
        while (cyc < c + 13) tick();
        en = 1'b1;
        goto_cyc(c + 14);
        n_checks++;
        if ({gnt, mac_en, mac_clr} !== {3'b001, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL en_resume got gnt=%b en=%b clr=%b required 001 1 1", gnt, mac_en, mac_clr);
        end
        wait_idle("en_low");
    endtask

    task automatic test_reset_mid_job();
        int c;
        c = cyc;
        push_job(0);
        pulse_req(3'b001);
        while (cyc < c + 12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        n_checks++;
        if ({gnt, tap_idx, mac_en, mac_clr, mac_last, done, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid got gnt=%b tap=%0d en=%b clr=%b last=%b done=%b busy=%b ovr=%b required all 0",
                     gnt, tap_idx, mac_en, mac_clr, mac_last, done, busy, overrun);
        end
        repeat (30) tick();
        c = cyc;
        push_job(0);
        pulse_req(3'b001);
        goto_cyc(c + 2);
        n_checks++;
        if ({gnt, tap_idx, mac_clr} !== {3'b001, TW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL rst_restart got gnt=%b tap=%0d clr=%b required 001 0 1", gnt, tap_idx, mac_clr);
        end
        wait_idle("rst_restart");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            last_done_cyc[i] = -1;
            done_cnt[i] = 0;
        end
        test_reset();
        test_single_fir();
        test_single_hb1();
        test_back_to_back();
        test_overrun();
        test_en_low();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end

endmodule

// File: doc/decim_mac_scheduler.md
Name: decim_mac_scheduler

Overview:
- Time-multiplexes one shared multiply-accumulate unit between the three post-CIC decimation stages: FIR (R=2) and halfband stages 1 and 2.
- Each stage pulses a request when it has a new output to compute. The scheduler arbitrates between them, then sequences the tap indices for the granted stage, along with accumulator clear/last strobes and a completion pulse.
- Sits between the stage sample buffers and the shared MAC inside the decimation top level. Flags any stage whose new request arrives while its previous job is still outstanding.

Parameters:
- FIR_NUM_TAPS, 26, FIR tap count; every tap is scheduled.
- HB_NUM_TAPS, 7, halfband tap count (4k+3 form); only nonzero taps are scheduled, i.e. even indices plus the centre (HB_NUM_TAPS-1)/2.
- TAP_W, 5, width of tap_idx; must satisfy 2^TAP_W >= max(FIR_NUM_TAPS, HB_NUM_TAPS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  when low, no new grant is issued; an in-flight job runs to completion.
- req  in  3  single-cycle job request pulses; bit0=FIR, bit1=HB1, bit2=HB2.
- gnt  out  3  one-hot owner of the MAC; 0 when idle.
- tap_idx  out  TAP_W  coefficient/sample index for the current MAC cycle.
- mac_en  out  1  MAC performs a multiply-accumulate this cycle.
- mac_clr  out  1  first tap of a job; MAC loads the product instead of accumulating.
- mac_last  out  1  final tap of a job.
- done  out  3  one-cycle pulse per stage; the stage's result is valid at the MAC output.
- busy  out  1  high when a job is in RUN state or any request is pending.
- overrun  out  3  sticky per-stage flag: a request arrived while that stage was still active.

Behaviour:
- Reset: all outputs 0, pending[2:0]=0, state IDLE, tap counter 0. Reset mid-job aborts the job with no done pulse and drops all pending requests.
- Request capture: req[s] sampled at a clk edge sets pending[s].
  - Stage s is "active" when pending[s]=1, or when gnt[s]=1 in RUN state.
  - A req[s] arriving while s is active sets overrun[s]; the job is not duplicated.
  - overrun clears only on rst.
- Arbitration is fixed priority, FIR > HB1 > HB2, evaluated in IDLE and DONE states when en=1.
- States:
  - IDLE: if en and any pending, go to RUN. On entry: gnt=winner, pending[winner] cleared, first tap issued. Otherwise stay in IDLE.
  - RUN: mac_en=1 every cycle.
    - mac_clr=1 on the first cycle only; mac_last=1 on the final cycle.
    - tap_idx steps each cycle: 0..25 for FIR; 0,2,3,4,6 for HB at defaults.
    - After the mac_last cycle, go to DONE.
  - DONE: one cycle. done[owner]=1, gnt=0, mac_en=0. Re-arbitrate: go to RUN with the next winner if en and any pending, else go to IDLE.
- Latency: req in cycle c, with the scheduler idle, gives first mac_en/mac_clr in cycle c+2.
  - FIR job: mac_en for cycles c+2..c+27, done in c+28.
  - HB job: 5 MAC cycles, done on the 6th cycle after the first mac_en.
  - Back-to-back jobs are separated by exactly one DONE cycle.
- Simultaneous events:
  - req[s] in the DONE cycle of stage s sets pending[s] without setting overrun.
  - req[s] in the mac_last cycle of s sets overrun[s].
  - Multiple req bits in the same cycle all set their pending bits.
- en low: the current job completes. DONE goes to IDLE; pending bits are retained and requests are still captured and overrun-checked.
- Outputs are registered. When mac_en=0, tap_idx holds 0, and mac_clr and mac_last are 0.

Test Plan:
- Single FIR req in cycle 10 -> gnt=001 cycles 12..37; tap_idx 0..25; mac_clr only at 12; mac_last only at 37; done[0] at 38; busy low from 39.
- Single HB1 req -> tap_idx sequence 0,2,3,4,6 over 5 cycles; mac_last on tap 6; done[1] the next cycle.
- req=111 in one cycle -> jobs run in order FIR, HB1, HB2, each separated by one DONE cycle; all three done pulses occur once; overrun stays 000.
- FIR req repeated mid-job (cycle 20) and again in its mac_last cycle -> overrun[0]=1 and stays set; only one FIR done is produced for the original job.
- en=0 during HB2 job with an FIR request pending -> HB2 completes and scheduler goes to IDLE; FIR starts 1 cycle after en returns high.
- rst pulse mid FIR job -> next cycle all outputs 0, no done pulse; a fresh req afterwards restarts at tap_idx 0 with mac_clr.
